cp0_access_sched: RTL and testbench

CP0_ACCESS_SCHED -- requirements
Module: cp0_access_sched

---
 rtl/cp0_access_sched.sv | 201 ++++++++++++++++++++
 tb/tb_cp0_access_sched.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_access_sched.sv
// Arbitrates the single CP0 register-file port between pipeline MTC0/MFC0
// and the multi-step exception-entry and ERET read-modify-write sequences.
module cp0_access_sched (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pipe_write_en,
    input  logic        pipe_read_en,
    input  logic [7:0]  pipe_addr,
    input  logic [31:0] pipe_write_data,
    output logic [31:0] pipe_read_data,
    output logic        pipe_read_valid,
    input  logic        exc_req,
    input  logic [4:0]  exc_code,
    input  logic [31:0] exc_pc,
    input  logic        exc_in_ds,
    input  logic        exc_has_badv,
    input  logic [31:0] exc_badv,
    output logic        exc_ack,
    input  logic        eret_req,
    output logic        eret_ack,
    output logic        stall,
    output logic        rf_en,
    output logic        rf_we,
    output logic [7:0]  rf_addr,
    output logic [31:0] rf_wdata,
    input  logic [31:0] rf_rdata
);

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 5;

    localparam logic [AW-1:0] ADDR_BADV   = 8'h40;
    localparam logic [AW-1:0] ADDR_STATUS = 8'h60;
    localparam logic [AW-1:0] ADDR_CAUSE  = 8'h68;
    localparam logic [AW-1:0] ADDR_EPC    = 8'h70;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_PRD    = 4'd1,
        S_X_BADV = 4'd2,
        S_X_EPC  = 4'd3,
        S_X_CRD  = 4'd4,
        S_X_CWR  = 4'd5,
        S_X_SRD  = 4'd6,
        S_X_SWR  = 4'd7,
        S_E_SRD  = 4'd8,
        S_E_SWR  = 4'd9
    } state_t;

    state_t        state;
    state_t        state_nxt;

    logic [CW-1:0] code_q;
    logic [DW-1:0] pc_q;
    logic          in_ds_q;
    logic          has_badv_q;
    logic [DW-1:0] badv_q;

    logic          accept_win;

    // IDLE and PRD are the only states that look at new requests
    assign accept_win = (state == S_IDLE) || (state == S_PRD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Exception context captured on acceptance, used by the later write steps
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_q     <= '0;
            pc_q       <= '0;
            in_ds_q    <= 1'b0;
            has_badv_q <= 1'b0;
            badv_q     <= '0;
        end else if (accept_win && exc_req) begin
            code_q     <= exc_code;
            pc_q       <= exc_pc;
            in_ds_q    <= exc_in_ds;
            has_badv_q <= exc_has_badv;
            badv_q     <= exc_badv;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_PRD: begin
                if (exc_req) begin
                    state_nxt = exc_has_badv ? S_X_BADV : S_X_EPC;
                end else if (eret_req) begin
                    state_nxt = S_E_SRD;
                end else if (!pipe_write_en && pipe_read_en) begin
                    state_nxt = S_PRD;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_X_BADV: state_nxt = S_X_EPC;
            S_X_EPC:  state_nxt = S_X_CRD;
            S_X_CRD:  state_nxt = S_X_CWR;
            S_X_CWR:  state_nxt = S_X_SRD;
            S_X_SRD:  state_nxt = S_X_SWR;
            S_X_SWR:  state_nxt = S_IDLE;
            S_E_SRD:  state_nxt = S_E_SWR;
            S_E_SWR:  state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Everything is gated by rst_n so outputs drop the instant reset asserts
    always_comb begin
        rf_en           = 1'b0;
        rf_we           = 1'b0;
        rf_addr         = '0;
        rf_wdata        = '0;
        pipe_read_data  = '0;
        pipe_read_valid = 1'b0;
        exc_ack         = 1'b0;
        eret_ack        = 1'b0;
        stall           = 1'b0;
        if (rst_n) begin
            case (state)
                S_IDLE, S_PRD: begin
                    if (state == S_PRD) begin
                        pipe_read_valid = 1'b1;
                        pipe_read_data  = rf_rdata;
                    end
                    stall = exc_req || eret_req;
                    if (!exc_req && !eret_req) begin
                        if (pipe_write_en) begin
                            rf_en    = 1'b1;
                            rf_we    = 1'b1;
                            rf_addr  = pipe_addr;
                            rf_wdata = pipe_write_data;
                        end else if (pipe_read_en) begin
                            rf_en   = 1'b1;
                            rf_addr = pipe_addr;
                        end
                    end
                end
                S_X_BADV: begin
                    stall    = 1'b1;
                    rf_en    = 1'b1;
                    rf_we    = 1'b1;
                    rf_addr  = ADDR_BADV;
                    rf_wdata = badv_q;
                end
                S_X_EPC: begin
                    stall    = 1'b1;
                    rf_en    = 1'b1;
                    rf_we    = 1'b1;
                    rf_addr  = ADDR_EPC;
                    rf_wdata = in_ds_q ? (pc_q - DW'(4)) : pc_q;
                end
                S_X_CRD: begin
                    stall   = 1'b1;
                    rf_en   = 1'b1;
                    rf_addr = ADDR_CAUSE;
                end
                S_X_CWR: begin
                    stall    = 1'b1;
                    rf_en    = 1'b1;
                    rf_we    = 1'b1;
                    rf_addr  = ADDR_CAUSE;
                    rf_wdata = {in_ds_q, rf_rdata[30:7], code_q, rf_rdata[1:0]};
                end
                S_X_SRD, S_E_SRD: begin
                    stall   = 1'b1;
                    rf_en   = 1'b1;
                    rf_addr = ADDR_STATUS;
                end
                S_X_SWR: begin
                    stall    = 1'b1;
                    rf_en    = 1'b1;
                    rf_we    = 1'b1;
                    rf_addr  = ADDR_STATUS;
                    rf_wdata = {rf_rdata[31:2], 1'b1, rf_rdata[0]};
                    exc_ack  = 1'b1;
                end
                S_E_SWR: begin
                    stall    = 1'b1;
                    rf_en    = 1'b1;
                    rf_we    = 1'b1;
                    rf_addr  = ADDR_STATUS;
                    rf_wdata = {rf_rdata[31:2], 1'b0, rf_rdata[0]};
                    eret_ack = 1'b1;
                end
                default: begin
                    stall = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cp0_access_sched.sv
// Directed plus randomized bench for cp0_access_sched against a CP0 register
// file model and per-transaction expected access lists.
module tb_cp0_access_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pipe_write_en = 1'b0;
    logic        pipe_read_en = 1'b0;
    logic [7:0]  pipe_addr = '0;
    logic [31:0] pipe_write_data = '0;
    logic [31:0] pipe_read_data;
    logic        pipe_read_valid;
    logic        exc_req = 1'b0;
    logic [4:0]  exc_code = '0;
    logic [31:0] exc_pc = '0;
    logic        exc_in_ds = 1'b0;
    logic        exc_has_badv = 1'b0;
    logic [31:0] exc_badv = '0;
    logic        exc_ack;
    logic        eret_req = 1'b0;
    logic        eret_ack;
    logic        stall;
    logic        rf_en;
    logic        rf_we;
    logic [7:0]  rf_addr;
    logic [31:0] rf_wdata;
    logic [31:0] rf_rdata = '0;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:255];

    cp0_access_sched dut (
        .clk(clk), .rst_n(rst_n),
        .pipe_write_en(pipe_write_en), .pipe_read_en(pipe_read_en),
        .pipe_addr(pipe_addr), .pipe_write_data(pipe_write_data),
        .pipe_read_data(pipe_read_data), .pipe_read_valid(pipe_read_valid),
        .exc_req(exc_req), .exc_code(exc_code), .exc_pc(exc_pc),
        .exc_in_ds(exc_in_ds), .exc_has_badv(exc_has_badv), .exc_badv(exc_badv),
        .exc_ack(exc_ack), .eret_req(eret_req), .eret_ack(eret_ack), .stall(stall),
        .rf_en(rf_en), .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata),
        .rf_rdata(rf_rdata)
    );

    always #5 clk = ~clk;

    // Register file: synchronous write, read data one cycle after the strobe
    always @(posedge clk) begin
        if (rf_en && rf_we) mem[rf_addr] <= rf_wdata;
        if (rf_en && !rf_we) rf_rdata <= mem[rf_addr];
    end

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        chk32(tag, 32'(obs), 32'(exp));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk1({tag, ".rf_en"}, rf_en, 1'b0);
        chk1({tag, ".stall"}, stall, 1'b0);
        chk1({tag, ".valid"}, pipe_read_valid, 1'b0);
        chk32({tag, ".rdata"}, pipe_read_data, 32'h0);
        chk1({tag, ".exc_ack"}, exc_ack, 1'b0);
        chk1({tag, ".eret_ack"}, eret_ack, 1'b0);
    endtask

    task automatic chk_op(input string tag, input logic we, input logic [7:0] addr,
                          input logic [31:0] wd, input logic xa, input logic ea);
        chk1({tag, ".rf_en"}, rf_en, 1'b1);
        chk1({tag, ".rf_we"}, rf_we, we);
        chk32({tag, ".rf_addr"}, 32'(rf_addr), 32'(addr));
        if (we) chk32({tag, ".rf_wdata"}, rf_wdata, wd);
        chk1({tag, ".stall"}, stall, 1'b1);
        chk1({tag, ".exc_ack"}, exc_ack, xa);
        chk1({tag, ".eret_ack"}, eret_ack, ea);
    endtask

    task automatic do_mtc0(input logic [7:0] addr, input logic [31:0] data);
        pipe_write_en = 1'b1; pipe_addr = addr; pipe_write_data = data;
        @(negedge clk);
        chk1("mtc0.rf_en", rf_en, 1'b1);
        chk1("mtc0.rf_we", rf_we, 1'b1);
        chk32("mtc0.rf_addr", 32'(rf_addr), 32'(addr));
        chk32("mtc0.rf_wdata", rf_wdata, data);
        chk1("mtc0.stall", stall, 1'b0);
        step();
        pipe_write_en = 1'b0;
        chk32("mtc0.mem", mem[addr], data);
        @(negedge clk);
        chk_quiet("mtc0.after");
        step();
    endtask

    // follow: 0 nothing, 1 MTC0 in the result cycle, 2 MFC0 in the result cycle
    task automatic do_mfc0(input logic [7:0] addr, input int follow,
                           input logic [7:0] addr2, input logic [31:0] wd2);
        logic [31:0] exp1;
        logic [31:0] exp2;
        exp1 = mem[addr];
        exp2 = mem[addr2];
        pipe_read_en = 1'b1; pipe_addr = addr;
        @(negedge clk);
        chk1("mfc0.rf_en", rf_en, 1'b1);
        chk1("mfc0.rf_we", rf_we, 1'b0);
        chk32("mfc0.rf_addr", 32'(rf_addr), 32'(addr));
        chk1("mfc0.stall", stall, 1'b0);
        chk1("mfc0.early_valid", pipe_read_valid, 1'b0);
        step();
        pipe_read_en = (follow == 2);
        pipe_write_en = (follow == 1);
        pipe_addr = addr2; pipe_write_data = wd2;
        @(negedge clk);
        chk1("mfc0.valid", pipe_read_valid, 1'b1);
        chk32("mfc0.data", pipe_read_data, exp1);
        chk1("mfc0.stall2", stall, 1'b0);
        chk1("mfc0.follow_en", rf_en, follow != 0);
        if (follow != 0) begin
            chk1("mfc0.follow_we", rf_we, follow == 1);
            chk32("mfc0.follow_addr", 32'(rf_addr), 32'(addr2));
        end
        step();
        pipe_read_en = 1'b0; pipe_write_en = 1'b0;
        if (follow == 1) chk32("mfc0.follow_mem", mem[addr2], wd2);
        if (follow == 2) begin
            @(negedge clk);
            chk1("mfc0.valid2", pipe_read_valid, 1'b1);
            chk32("mfc0.data2", pipe_read_data, exp2);
            step();
        end
        @(negedge clk);
        chk_quiet("mfc0.after");
        step();
    endtask

    task automatic do_eret();
        logic [31:0] s0;
        s0 = mem[8'h60];
        eret_req = 1'b1;
        @(negedge clk);
        chk1("eret.c0.stall", stall, 1'b1);
        chk1("eret.c0.rf_en", rf_en, 1'b0);
        chk1("eret.c0.ack", eret_ack, 1'b0);
        step();
        @(negedge clk);
        chk_op("eret.srd", 1'b0, 8'h60, 32'h0, 1'b0, 1'b0);
        step();
        @(negedge clk);
        chk_op("eret.swr", 1'b1, 8'h60, s0 & ~32'h2, 1'b0, 1'b1);
        step();
        eret_req = 1'b0;
        chk32("eret.status", mem[8'h60], s0 & ~32'h2);
        @(negedge clk);
        chk_quiet("eret.after");
        step();
    endtask

    task automatic do_exc(input logic [4:0] code, input logic [31:0] pc, input logic ds,
                          input logic hb, input logic [31:0] badv,
                          input logic with_eret, input logic with_write);
        logic        we [0:7];
        logic [7:0]  ad [0:7];
        logic [31:0] wd [0:7];
        int          n;
        logic [31:0] c0, s0, w0, epc, cause, status;
        c0 = mem[8'h68]; s0 = mem[8'h60]; w0 = mem[8'h10];
        epc    = ds ? pc - 32'd4 : pc;
        cause  = (c0 & ~32'h8000_007C) | (32'(ds) << 31) | (32'(code) << 2);
        status = s0 | 32'h2;
        n = 0;
        if (hb) begin we[n] = 1'b1; ad[n] = 8'h40; wd[n] = badv; n++; end
        we[n] = 1'b1; ad[n] = 8'h70; wd[n] = epc;    n++;
        we[n] = 1'b0; ad[n] = 8'h68; wd[n] = 32'h0;  n++;
        we[n] = 1'b1; ad[n] = 8'h68; wd[n] = cause;  n++;
        we[n] = 1'b0; ad[n] = 8'h60; wd[n] = 32'h0;  n++;
        we[n] = 1'b1; ad[n] = 8'h60; wd[n] = status; n++;
        exc_req = 1'b1; exc_code = code; exc_pc = pc; exc_in_ds = ds;
        exc_has_badv = hb; exc_badv = badv; eret_req = with_eret;
        pipe_write_en = with_write; pipe_addr = 8'h10; pipe_write_data = ~w0;
        @(negedge clk);
        chk1("exc.c0.stall", stall, 1'b1);
        chk1("exc.c0.rf_en", rf_en, 1'b0);
        chk1("exc.c0.ack", exc_ack, 1'b0);
        step();
        // Fields change after acceptance to show the scheduler used its own copy
        exc_code = ~code; exc_pc = ~pc; exc_in_ds = ~ds; exc_badv = ~badv;
        for (int i = 0; i < n; i++) begin
            pipe_write_en = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk_op($sformatf("exc.op%0d", i), we[i], ad[i], wd[i], i == n - 1, 1'b0);
            step();
        end
        exc_req = 1'b0; pipe_write_en = 1'b0;
        chk32("exc.dropped_write", mem[8'h10], w0);
        if (hb) chk32("exc.mem_badv", mem[8'h40], badv);
        chk32("exc.mem_epc", mem[8'h70], epc);
        chk32("exc.mem_cause", mem[8'h68], cause);
        chk32("exc.mem_status", mem[8'h60], status);
        if (with_eret) begin
            do_eret();
        end else begin
            @(negedge clk);
            chk_quiet("exc.after");
            step();
        end
    endtask

    initial begin
        logic [31:0] c0, s0;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;

        // Reset must mask even combinational request decoding
        pipe_write_en = 1'b1; exc_req = 1'b1;
        #2;
        chk_quiet("reset");
        chk1("reset.rf_we", rf_we, 1'b0);
        chk32("reset.rf_wdata", rf_wdata, 32'h0);
        pipe_write_en = 1'b0; exc_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();

        do_mtc0(8'h60, 32'h0000FF01);
        mem[8'h68] = 32'h12345678;
        do_mfc0(8'h68, 0, 8'h00, 32'h0);

        mem[8'h68] = 32'h0; mem[8'h60] = 32'h0000FF00;
        do_exc(5'h04, 32'hBFC00100, 1'b1, 1'b1, 32'h00000003, 1'b0, 1'b0);
        chk32("d28.badv", mem[8'h40], 32'h00000003);
        chk32("d28.epc", mem[8'h70], 32'hBFC000FC);
        chk32("d28.cause", mem[8'h68], 32'h80000010);
        chk32("d28.status", mem[8'h60], 32'h0000FF02);

        do_exc(5'h0C, 32'h80001000, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

        mem[8'h60] = 32'h0000FF03;
        do_eret();
        chk32("d30.status", mem[8'h60], 32'h0000FF01);

        do_mfc0(8'h70, 1, 8'h20, 32'hCAFE0001);
        do_mfc0(8'h20, 2, 8'h70, 32'h0);

        // Reset in the middle of the Cause write-back
        c0 = mem[8'h68]; s0 = mem[8'h60];
        exc_req = 1'b1; exc_code = 5'h0A; exc_pc = 32'h00400000; exc_has_badv = 1'b0;
        exc_in_ds = 1'b0;
        @(negedge clk); step();
        @(negedge clk); step();
        @(negedge clk); step();
        @(negedge clk);
        chk_op("rst.cwr", 1'b1, 8'h68, (c0 & ~32'h8000_007C) | 32'h28, 1'b0, 1'b0);
        #1;
        rst_n = 1'b0; exc_req = 1'b0; pipe_write_en = 1'b1; pipe_addr = 8'h30;
        #1;
        chk_quiet("rst.mid");
        chk1("rst.mid.rf_we", rf_we, 1'b0);
        chk32("rst.mid.rf_addr", 32'(rf_addr), 32'h0);
        step();
        pipe_write_en = 1'b0;
        chk32("rst.cause_kept", mem[8'h68], c0);
        chk32("rst.status_kept", mem[8'h60], s0);
        @(negedge clk);
        rst_n = 1'b1;
        pipe_write_en = 1'b1; pipe_addr = 8'h31; pipe_write_data = 32'hA5A5_0031;
        #1;
        chk1("rst.first.rf_en", rf_en, 1'b1);
        chk1("rst.first.stall", stall, 1'b0);
        step();
        pipe_write_en = 1'b0;
        chk32("rst.first.mem", mem[8'h31], 32'hA5A5_0031);
        chk32("rst.status_after", mem[8'h60], s0);
        @(negedge clk);
        chk_quiet("rst.after");
        step();

        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 4))
                0: do_mtc0(8'($urandom), $urandom);
                1: do_mfc0(8'($urandom), int'($urandom_range(0, 2)), 8'($urandom), $urandom);
                2: do_exc(5'($urandom), $urandom, 1'($urandom), 1'($urandom), $urandom,
                          1'b0, 1'b0);
                3: do_eret();
                default: do_exc(5'($urandom), $urandom, 1'($urandom), 1'($urandom),
                                $urandom, 1'($urandom), 1'($urandom));
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
